udp_tx_pattern_gen: RTL and testbench

Packet source for the 40G UDP transmit path. It drives the 512-bit fragment stream that feeds the Ethernet/UDP TX encapsulator: `dataOut` valid/ready/last, data, byteNum and tkeep. It emits fixed-length packets with a deterministic, sequence-stamped byte pattern so the receive-side checker can validate it. Packets are counted, and inter-packet gaps are programmable.

---
 rtl/udp_tx_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_udp_tx_pattern_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_pattern_gen.sv
// Fixed-length, sequence-stamped 512-bit packet source for the UDP TX path.
// Each byte is (global byte index + packet seq) mod 256, with programmable gaps.
module udp_tx_pattern_gen #(
  parameter int PKT_BYTES  = 1024,
  parameter int PKT_COUNT  = 0,
  parameter int GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  output logic         io_dataOut_valid,
  input  logic         io_dataOut_ready,
  output logic         io_dataOut_payload_last,
  output logic [511:0] io_dataOut_payload_fragment_data,
  output logic [15:0]  io_dataOut_payload_fragment_byteNum,
  output logic [63:0]  io_dataOut_payload_fragment_tkeep,
  output logic         busy,
  output logic [31:0]  pkt_cnt
);

  localparam int BEATS = (PKT_BYTES + 63) / 64;
  localparam int REM   = PKT_BYTES - 64 * (BEATS - 1);
  localparam logic [7:0]  LAST_BEAT = 8'(BEATS - 1);
  localparam logic [7:0]  GAP_LAST  =
    8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [63:0] LAST_KEEP = {64{1'b1}} >> (64 - REM);
  localparam logic [15:0] BYTE_NUM  = 16'(PKT_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t       r_state;
  state_t       w_state_n;
  logic [7:0]   r_beat;
  logic [7:0]   r_gap_cnt;
  logic [31:0]  r_seq;
  logic [31:0]  r_pkt_cnt;
  logic         r_stop_seen;
  logic         r_busy;
  logic         r_valid;
  logic         r_last;
  logic [511:0] r_data;
  logic [63:0]  r_tkeep;
  logic [15:0]  r_byte_num;

  logic         w_fire;
  logic         w_stop_seen;
  logic         w_count_done;
  logic         w_load;
  logic         w_pkt_done;
  logic [7:0]   w_nbeat;
  logic [31:0]  w_nseq;
  logic         w_nlast;
  logic [63:0]  w_nkeep;
  logic [511:0] w_ndata;

  assign w_fire       = r_valid && io_dataOut_ready;
  assign w_stop_seen  = r_stop_seen || stop;
  assign w_count_done = (PKT_COUNT != 0) &&
                        (r_pkt_cnt + 32'd1 == 32'(PKT_COUNT));

  always_comb begin
    w_state_n  = r_state;
    w_load     = 1'b0;
    w_pkt_done = 1'b0;
    w_nbeat    = 8'd0;
    w_nseq     = r_seq;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_SEND;
          w_load    = 1'b1;
          w_nseq    = 32'd0;
        end
      end
      S_SEND: begin
        if (w_fire) begin
          if (!r_last) begin
            w_load  = 1'b1;
            w_nbeat = r_beat + 8'd1;
          end else begin
            w_pkt_done = 1'b1;
            w_nseq     = r_seq + 32'd1;
            if (w_stop_seen || w_count_done) begin
              w_state_n = S_IDLE;
            end else if (GAP_CYCLES > 0) begin
              w_state_n = S_GAP;
            end else begin
              w_load = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          if (w_stop_seen) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_SEND;
            w_load    = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Beat contents are built ahead of time so every output is a flop.
  assign w_nlast = (w_nbeat == LAST_BEAT);
  assign w_nkeep = w_nlast ? LAST_KEEP : {64{1'b1}};

  always_comb begin
    w_ndata = '0;
    for (int i = 0; i < 64; i++) begin
      if (w_nkeep[i]) begin
        w_ndata[8*i +: 8] = 8'(i) + {w_nbeat[1:0], 6'd0} + w_nseq[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_beat      <= 8'd0;
      r_gap_cnt   <= 8'd0;
      r_seq       <= 32'd0;
      r_pkt_cnt   <= 32'd0;
      r_stop_seen <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_tkeep     <= '0;
      r_byte_num  <= '0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != S_IDLE);
      if (r_state == S_IDLE && start) begin
        r_stop_seen <= 1'b0;
        r_pkt_cnt   <= 32'd0;
        r_seq       <= 32'd0;
      end else if (r_state != S_IDLE && stop) begin
        r_stop_seen <= 1'b1;
      end
      if (w_pkt_done) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
        r_seq     <= r_seq + 32'd1;
      end
      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 8'd1;
      end else begin
        r_gap_cnt <= 8'd0;
      end
      if (w_load) begin
        r_beat     <= w_nbeat;
        r_valid    <= 1'b1;
        r_last     <= w_nlast;
        r_data     <= w_ndata;
        r_tkeep    <= w_nkeep;
        r_byte_num <= BYTE_NUM;
      end else if (w_fire) begin
        r_beat     <= 8'd0;
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
        r_data     <= '0;
        r_tkeep    <= '0;
        r_byte_num <= '0;
      end
    end
  end

  assign io_dataOut_valid                    = r_valid;
  assign io_dataOut_payload_last             = r_last;
  assign io_dataOut_payload_fragment_data    = r_data;
  assign io_dataOut_payload_fragment_byteNum = r_byte_num;
  assign io_dataOut_payload_fragment_tkeep   = r_tkeep;
  assign busy                                = r_busy;
  assign pkt_cnt                             = r_pkt_cnt;

endmodule

// File: tb/tb_udp_tx_pattern_gen.sv
// Scoreboard bench: four generator configurations, a byte-index reference
// model feeding per-instance queues, and a negedge monitor.
module tb_udp_tx_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   rst, st, sp, vld, lst, bsy, rdy;
  logic         rnd1 = 1'b1;
  logic         rnd3 = 1'b1;
  logic [511:0] dat [4];
  logic [63:0]  kp  [4];
  logic [15:0]  bn  [4];
  logic [31:0]  pc  [4];

  assign rdy = {rnd3, 1'b1, rnd1, 1'b1};

  function automatic int f_pb(input int g);
    case (g)
      0: return 100;
      1: return 256;
      2: return 1;
      default: return 1024;
    endcase
  endfunction

  function automatic int f_pc(input int g);
    case (g)
      0: return 2;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int f_gp(input int g);
    case (g)
      0: return 0;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    udp_tx_pattern_gen #(
      .PKT_BYTES (f_pb(g)),
      .PKT_COUNT (f_pc(g)),
      .GAP_CYCLES(f_gp(g))
    ) u_dut (
      .clk                                (clk),
      .reset                              (rst[g]),
      .start                              (st[g]),
      .stop                               (sp[g]),
      .io_dataOut_valid                   (vld[g]),
      .io_dataOut_ready                   (rdy[g]),
      .io_dataOut_payload_last            (lst[g]),
      .io_dataOut_payload_fragment_data   (dat[g]),
      .io_dataOut_payload_fragment_byteNum(bn[g]),
      .io_dataOut_payload_fragment_tkeep  (kp[g]),
      .busy                               (bsy[g]),
      .pkt_cnt                            (pc[g])
    );
  end

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic [15:0]  bn;
    logic         l;
  } beat_t;

  beat_t exp_q [4][$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string nm,
                                input logic [511:0] act,
                                input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: byte at global index idx of packet n is (idx + n) mod 256.
  function automatic beat_t exp_beat(input int pbytes, input int n,
                                     input int b);
    beat_t x;
    x.d  = '0;
    x.k  = '0;
    x.bn = 16'(pbytes);
    x.l  = (64 * (b + 1) >= pbytes);
    for (int i = 0; i < 64; i++) begin
      int idx;
      idx = 64 * b + i;
      if (idx < pbytes) begin
        x.k[i]        = 1'b1;
        x.d[8*i +: 8] = 8'((idx + n) % 256);
      end
    end
    return x;
  endfunction

  task automatic push_run(input int g, input int n0, input int npkt);
    int pb;
    pb = f_pb(g);
    for (int p = 0; p < npkt; p++)
      for (int b = 0; 64 * b < pb; b++)
        exp_q[g].push_back(exp_beat(pb, n0 + p, b));
  endtask

  bit    hold  [4];
  bit    pend  [4];
  bit    inpkt [4];
  int    idle  [4];
  int    acc   [4];
  beat_t held  [4];

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      beat_t cur;
      beat_t ex;
      cur.d  = dat[g];
      cur.k  = kp[g];
      cur.bn = bn[g];
      cur.l  = lst[g];
      if (rst[g]) begin
        hold[g]  = 1'b0;
        pend[g]  = 1'b0;
        inpkt[g] = 1'b0;
        idle[g]  = 0;
        acc[g]   = 0;
      end else begin
        if (hold[g]) begin
          check($sformatf("dut%0d_stable_vld", g), 512'(vld[g]), 512'd1);
          check($sformatf("dut%0d_stable_data", g), cur.d, held[g].d);
          check($sformatf("dut%0d_stable_ctl", g),
                512'({cur.k, cur.bn, cur.l}),
                512'({held[g].k, held[g].bn, held[g].l}));
        end
        if (inpkt[g])
          check($sformatf("dut%0d_no_bubble", g), 512'(vld[g]), 512'd1);
        if (pend[g]) begin
          if (vld[g]) begin
            check($sformatf("dut%0d_gap", g), 512'(idle[g]),
                  512'(f_gp(g)));
            pend[g] = 1'b0;
          end else if (!bsy[g]) begin
            pend[g] = 1'b0;
          end else begin
            idle[g]++;
          end
        end
        if (vld[g] && rdy[g]) begin
          if (exp_q[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d_extra_beat: got beat %0d expected none",
                     g, acc[g]);
          end else begin
            ex = exp_q[g].pop_front();
            check($sformatf("dut%0d_data b%0d", g, acc[g]), cur.d, ex.d);
            check($sformatf("dut%0d_ctl b%0d", g, acc[g]),
                  512'({cur.k, cur.bn, cur.l}), 512'({ex.k, ex.bn, ex.l}));
          end
          acc[g]++;
          inpkt[g] = !cur.l;
          if (cur.l) begin
            pend[g] = 1'b1;
            idle[g] = 0;
          end
        end
        hold[g] = vld[g] && !rdy[g];
        held[g] = cur;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd1 = 1'($urandom_range(0, 1));
      rnd3 = 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk);
    #1 st[g] = 1'b1;
    @(posedge clk);
    #1 st[g] = 1'b0;
    check($sformatf("dut%0d_start_vld", g), 512'(vld[g]), 512'd1);
    check($sformatf("dut%0d_start_busy", g), 512'(bsy[g]), 512'd1);
    check($sformatf("dut%0d_start_cnt", g), 512'(pc[g]), 512'd0);
  endtask

  task automatic pulse_stop(input int g);
    @(posedge clk);
    #1 sp[g] = 1'b1;
    @(posedge clk);
    #1 sp[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int lim);
    int k;
    k = 0;
    while (bsy[g] && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("dut%0d_idle", g), 512'(bsy[g]), 512'd0);
  endtask

  task automatic wait_acc(input int g, input int n, input int lim);
    int k;
    k = 0;
    while (acc[g] < n && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("dut%0d_acc_reached", g), 512'(acc[g] >= n), 512'd1);
  endtask

  task automatic check_quiet(input int g, input string tag);
    check($sformatf("dut%0d_%s_ctl", g, tag),
          512'({vld[g], lst[g], bsy[g], kp[g], bn[g], pc[g]}), 512'd0);
    check($sformatf("dut%0d_%s_data", g, tag), dat[g], 512'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 4'hF;
    st  = 4'h0;
    sp  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) check_quiet(g, "reset");
    rst = 4'h0;

    push_run(0, 0, 2);
    pulse_start(0);
    wait_idle(0, 200);
    check("dut0_pkt_cnt", 512'(pc[0]), 512'd2);

    push_run(2, 0, 3);
    pulse_start(2);
    wait_idle(2, 200);
    check("dut2_pkt_cnt", 512'(pc[2]), 512'd3);

    push_run(1, 0, 6);
    pulse_start(1);
    wait_acc(1, 22, 1000);
    pulse_stop(1);
    wait_idle(1, 1000);
    check("dut1_pkt_cnt", 512'(pc[1]), 512'd6);

    push_run(3, 0, 3);
    pulse_start(3);
    wait_acc(3, 20, 1000);
    @(posedge clk);
    #1 st[3] = 1'b1;
    @(posedge clk);
    #1 st[3] = 1'b0;
    check("dut3_busy_start_cnt", 512'(pc[3]), 512'd1);
    wait_acc(3, 33, 1000);
    check("dut3_pre_reset_cnt", 512'(pc[3]), 512'd2);
    @(posedge clk);
    #1 rst[3] = 1'b1;
    exp_q[3].delete();
    @(posedge clk);
    #1 check_quiet(3, "midreset");
    rst[3] = 1'b0;
    push_run(3, 0, 1);
    pulse_start(3);
    pulse_stop(3);
    wait_idle(3, 1000);
    check("dut3_restart_cnt", 512'(pc[3]), 512'd1);

    repeat (2) @(posedge clk);
    for (int g = 0; g < 4; g++)
      check($sformatf("dut%0d_queue_empty", g),
            512'(exp_q[g].size()), 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
